// File: rtl/int_to_flt_pkg.sv
// Shared types and constants for the int16 -> binary16 converter.
// Holds the FSM state encoding, exponent constants and default memory layout.
package int_to_flt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SIGN,
    NORM,
    ROUND,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  localparam int          BIAS        = 15;
  // Exponent for an MSB at bit 14 of the 15-bit magnitude.
  localparam logic [4:0]  EXP_TOP     = 5'(BIAS + 14);
  localparam logic [15:0] MAX_NEG     = 16'h8000;
  localparam logic [15:0] MAX_NEG_FLT = 16'hF800;

  localparam int DFLT_MEM_DEPTH = 256;
  localparam int DFLT_IN_ADDR   = 0;
  localparam int DFLT_OUT_ADDR  = 2;

endpackage

// File: rtl/dat_mem.sv
// Byte-wide data memory: two combinational read ports, one synchronous write port.
// Contents are deliberately not reset.
module dat_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [7:0]    rdata_a,
  output logic [7:0]    rdata_b
);

  logic [7:0] mem_core [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_core[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_core[raddr_a];
  assign rdata_b = mem_core[raddr_b];

endmodule

// File: rtl/int_to_flt.sv
// Converts a 16-bit two's-complement integer held in data_mem1 into IEEE-754
// binary16, writing the result back to the same memory; start/done handshake.
module int_to_flt
  import int_to_flt_pkg::*;
#(
  parameter int MEM_DEPTH = DFLT_MEM_DEPTH,
  parameter int IN_ADDR   = DFLT_IN_ADDR,
  parameter int OUT_ADDR  = DFLT_OUT_ADDR
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done
);

  localparam int AW = $clog2(MEM_DEPTH);

  state_t state_reg, state_next;

  logic          start_prev_reg;
  logic [15:0]   word_reg;
  logic [14:0]   m_reg;
  logic [4:0]    exp_reg;
  logic          s_reg;
  logic          special_reg;
  logic [15:0]   res_reg;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [7:0]    rd_lo;
  logic [7:0]    rd_hi;

  dat_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) data_mem1 (
    .clk     (clk),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .raddr_a (AW'(IN_ADDR)),
    .raddr_b (AW'(IN_ADDR + 1)),
    .rdata_a (rd_lo),
    .rdata_b (rd_hi)
  );

  // Zero and the most-negative value bypass normalisation entirely.
  logic        is_special;
  logic [14:0] mag;
  assign is_special = (word_reg == 16'h0000) || (word_reg == MAX_NEG);
  assign mag        = ~word_reg[14:0] + 15'd1;

  // Round-to-nearest-even on the normalised magnitude.
  logic        round_up;
  logic [11:0] sig_ext;
  logic [4:0]  exp_rnd;
  logic [9:0]  mant_rnd;
  assign round_up = m_reg[3] && (m_reg[4] || (|m_reg[2:0]));
  assign sig_ext  = {1'b0, m_reg[14:4]} + {11'd0, round_up};
  assign exp_rnd  = sig_ext[11] ? exp_reg + 5'd1 : exp_reg;
  assign mant_rnd = sig_ext[11] ? 10'd0 : sig_ext[9:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (start_prev_reg) state_next = LOAD;
        LOAD:    state_next = SIGN;
        SIGN:    state_next = is_special ? ROUND : NORM;
        NORM:    if (m_reg[14]) state_next = ROUND;
        ROUND:   state_next = WR_LO;
        WR_LO:   state_next = WR_HI;
        WR_HI:   state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    done      = (state_reg == DONE);
    mem_we    = (state_reg == WR_LO) || (state_reg == WR_HI);
    mem_waddr = (state_reg == WR_HI) ? AW'(OUT_ADDR + 1) : AW'(OUT_ADDR);
    mem_wdata = (state_reg == WR_HI) ? res_reg[15:8] : res_reg[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_prev_reg <= 1'b0;
      word_reg       <= '0;
      m_reg          <= '0;
      exp_reg        <= '0;
      s_reg          <= 1'b0;
      special_reg    <= 1'b0;
      res_reg        <= '0;
    end else begin
      start_prev_reg <= start;
      case (state_reg)
        LOAD: word_reg <= {rd_hi, rd_lo};
        SIGN: begin
          s_reg       <= word_reg[15];
          exp_reg     <= EXP_TOP;
          special_reg <= is_special;
          m_reg       <= word_reg[15] ? mag : word_reg[14:0];
        end
        NORM: begin
          if (!m_reg[14]) begin
            m_reg   <= {m_reg[13:0], 1'b0};
            exp_reg <= exp_reg - 5'd1;
          end
        end
        ROUND: begin
          if (special_reg) begin
            res_reg <= (word_reg == 16'h0000) ? 16'h0000 : MAX_NEG_FLT;
          end else begin
            res_reg <= {s_reg, exp_rnd, mant_rnd};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_flt.sv
// Self-checking bench for int_to_flt: directed table, random values against an
// arithmetic reference, handshake and mid-operation reset sequences.
module tb_int_to_flt;
  import int_to_flt_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic done;

  int compared   = 0;
  int mismatched = 0;

  int_to_flt dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] in_val;
    logic [15:0] exp_val;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: exact integer arithmetic with round-half-to-even on the discarded bits.
  function automatic logic [15:0] ref_flt(input logic [15:0] v);
    int val;
    int mag;
    int msb;
    int e;
    int sig;
    int sh;
    int rem;
    int half;
    bit s;
    val = int'($signed(v));
    if (val == 0) return 16'h0000;
    s   = (val < 0);
    mag = s ? -val : val;
    msb = 0;
    for (int i = 0; i < 16; i++) if (mag >= (1 << i)) msb = i;
    e = 15 + msb;
    if (msb <= 10) begin
      sig = mag << (10 - msb);
    end else begin
      sh   = msb - 10;
      sig  = mag >> sh;
      rem  = mag - (sig << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (sig % 2) == 1)) sig++;
    end
    if (sig == 2048) begin
      sig = 1024;
      e++;
    end
    return {s, 5'(e), 10'(sig % 1024)};
  endfunction

  // Load operand with start high for two cycles, drop start, wait for done.
  task automatic convert(input logic [15:0] val, output logic [15:0] res, output int lat);
    @(negedge clk);
    start = 1'b1;
    dut.data_mem1.mem_core[0] = val[7:0];
    dut.data_mem1.mem_core[1] = val[15:8];
    @(negedge clk);
    check("done_low_while_start", {31'd0, done}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!done && lat < 40) check("done_low_during_op", {31'd0, done}, 32'd0);
    end
    check("done_within_bound", {31'd0, done}, 32'd1);
    res = {dut.data_mem1.mem_core[3], dut.data_mem1.mem_core[2]};
  endtask

  vec_t vecs[9];
  logic [15:0] res;
  logic [15:0] rv;
  int lat;

  initial begin
    vecs[0] = '{16'h0001, 16'h3C00};
    vecs[1] = '{16'h0003, 16'h4200};
    vecs[2] = '{16'h0000, 16'h0000};
    vecs[3] = '{16'hFFC0, 16'hD400};
    vecs[4] = '{16'h8F00, 16'hF710};
    vecs[5] = '{16'h8000, 16'hF800};
    vecs[6] = '{16'h7FF0, 16'h77FF};
    vecs[7] = '{16'h4008, 16'h7400};
    vecs[8] = '{16'h7FF8, 16'h7800};

    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_state", 32'(dut.state_reg), 32'(IDLE));
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      convert(vecs[i].in_val, res, lat);
      $display("vec %0d: in=0x%04h out=0x%04h exp=0x%04h lat=%0d", i, vecs[i].in_val, res, vecs[i].exp_val, lat);
      check("vec_result", {16'd0, res}, {16'd0, vecs[i].exp_val});
      check("vec_latency_le_24", {31'd0, (lat <= 24)}, 32'd1);
      repeat (3) @(negedge clk);
      check("done_held", {31'd0, done}, 32'd1);
    end

    for (int i = 0; i < 40; i++) begin
      rv = 16'($urandom);
      convert(rv, res, lat);
      $display("rnd %0d: in=0x%04h out=0x%04h exp=0x%04h lat=%0d", i, rv, res, ref_flt(rv), lat);
      check("rnd_result", {16'd0, res}, {16'd0, ref_flt(rv)});
      check("rnd_latency_le_24", {31'd0, (lat <= 24)}, 32'd1);
    end

    // Reset while normalising a small value, then a clean conversion.
    @(negedge clk);
    start = 1'b1;
    dut.data_mem1.mem_core[0] = 8'h01;
    dut.data_mem1.mem_core[1] = 8'h00;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("in_norm_before_reset", 32'(dut.state_reg), 32'(NORM));
    reset = 1'b1;
    #1;
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_state", 32'(dut.state_reg), 32'(IDLE));
    $display("reset mid-NORM: done=%0b state=%0d", done, dut.state_reg);
    @(negedge clk);
    reset = 1'b0;
    convert(16'h0550, res, lat);
    $display("post-reset: in=0x0550 out=0x%04h exp=0x6550 lat=%0d", res, lat);
    check("post_reset_result", {16'd0, res}, 32'h0000_6550);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
